instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-003 instr  input  16  instruction word; fields: [15:12] op, [11:8] rdest, [7:4] opext, [3:0] rsrc, [7:0] imm8.
REQ-004 instr_valid  input  1  instr is valid this cycle.
REQ-005 instr_ready  output  1  sequencer accepts instr this cycle.
REQ-006 opcode  output  8  ALU opcode.
REQ-007 rsrc  output  4  source register-mux select.
REQ-008 rdest  output  4  destination register-mux select.
REQ-009 imm  output  16  immediate operand to the immediate/register mux.
REQ-010 ror_i  output  1  1 = ALU R1 takes imm; 0 = ALU R1 takes rsrc register.
REQ-011 reg_enable  output  16  one-hot register-bank write enable.
REQ-012 flag_en  output  1  flag-register update strobe.
REQ-013 halted  output  1  sequencer is in HALT.
REQ-014 retired  output  16  count of retired non-HALT instructions.

Function
REQ-015 The FSM SHALL have states FETCH, DECODE, EXEC, WB, HALT.
REQ-016 instr_ready SHALL be 1 only in FETCH; a transfer occurs when instr_valid&instr_ready on a rising edge, latching instr and moving to DECODE.
REQ-017 In FETCH with instr_valid=0, the FSM SHALL remain in FETCH with no enables asserted.
REQ-018 DECODE SHALL register the decoded fields and move to EXEC; the fields SHALL stay stable from DECODE through the end of WB.
REQ-019 Register format (op=4'h0): opcode={4'h0,opext}, ror_i=0, imm=0.
REQ-020 Immediate format (op 4'h1..4'hE): opcode={op,4'h0}, ror_i=1, imm=sign-extended imm8.
REQ-021 op=4'hF (HALT): the FSM SHALL go DECODE->HALT, issue no WB pulse, and not increment retired.
REQ-022 EXEC SHALL last exactly one cycle, with controls stable so the ALU settles; then WB.
REQ-023 WB SHALL last one cycle: reg_enable=1<<rdest and flag_en=1; then FETCH.
REQ-024 Write suppression: CMP (op=4'hB, or op=4'h0 with opext=4'hB) SHALL give reg_enable=0 and flag_en=1.
REQ-025 NOP (instr=16'h0000) SHALL give reg_enable=0 and flag_en=0, and SHALL still retire.
REQ-026 reg_enable SHALL be 16'h0000 in every state except WB, and never multi-hot.
REQ-027 Latency: acceptance at edge N gives the WB pulse in cycle N+3; throughput is one instruction per 4 cycles.
REQ-028 retired SHALL increment at the end of WB and wrap modulo 2^16 (16'hFFFF->16'h0000).
REQ-029 HALT SHALL be absorbing until reset: halted=1, instr_ready=0, reg_enable=0, flag_en=0.

Reset
REQ-030 While rst=0: state=FETCH; opcode, rsrc, rdest, imm, reg_enable, retired = 0; ror_i, flag_en, halted = 0. instr_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-031 Reset asserted mid-instruction (DECODE/EXEC/WB) SHALL abort it: no reg_enable or flag_en pulse, and no retire.

Structure
REQ-032 A shared package cpu_pkg SHALL hold:
- the state enum;
- constants OP_REG=4'h0, OP_CMPI=4'hB, OP_HALT=4'hF, EXT_NOP=4'h0, EXT_CMP=4'hB;
- the field bit positions.
REQ-033 The 4-to-16 one-hot decode SHALL be a sub-module onehot_dec4 (sel[3:0] -> out[15:0]); everything else stays in instr_sequencer.

Verification
REQ-034 Register ADD: accept 16'h0351 -> opcode 8'h05, rsrc 1, rdest 3, ror_i 0, and in cycle N+3 reg_enable 16'h0008 with flag_en 1; retired becomes 1.
REQ-035 Immediate: accept 16'h52FF -> opcode 8'h50, imm 16'hFFFF, ror_i 1, reg_enable 16'h0004 in WB.
REQ-036 CMP: accept 16'hB47F -> flag_en 1 and reg_enable 16'h0000 throughout; then 16'h00B2 -> same.
REQ-037 Backpressure: hold instr_valid=0 for 5 cycles -> stays in FETCH, instr_ready 1, no enables; then accept 16'h0000 -> no enables, retired increments.
REQ-038 HALT: accept 16'hF000 -> halted 1 from cycle N+2 and instr_ready 0 thereafter; further valid instructions are ignored; retired unchanged.
REQ-039 Reset: pull rst low during EXEC of 16'h0351 -> outputs 0 immediately; no reg_enable pulse ever appears; after release the FSM is in FETCH with retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared sequencer definitions: FSM states, opcode constants, instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_REG  = 4'h0;
  localparam logic [3:0] OP_CMPI = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] EXT_NOP = 4'h0;
  localparam logic [3:0] EXT_CMP = 4'hB;

  localparam int OP_LSB    = 12;
  localparam int RDEST_LSB = 8;
  localparam int OPEXT_LSB = 4;
  localparam int RSRC_LSB  = 0;
  localparam int IMM8_LSB  = 0;

  function automatic logic [3:0] field4(input logic [15:0] word, input int lsb);
    return word[lsb +: 4];
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/onehot_dec4.sv
// 4-to-16 one-hot decoder for the register-bank write enables; purely combinational.
module onehot_dec4 (
  input  logic [3:0]  sel,
  output logic [15:0] out
);

  assign out = 16'h0001 << sel;

endmodule

// File: rtl/instr_sequencer.sv
// Four-phase instruction sequencer (FETCH/DECODE/EXEC/WB) driving ALU and register-bank controls.
// One instruction per 4 cycles; write-back pulse 3 cycles after acceptance; HALT is absorbing.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [3:0]  rsrc,
  output logic [3:0]  rdest,
  output logic [15:0] imm,
  output logic        ror_i,
  output logic [15:0] reg_enable,
  output logic        flag_en,
  output logic        halted,
  output logic [15:0] retired
);

  state_e      state, state_nxt;
  logic        run_q;
  logic        is_halt_q, no_write_q, no_flag_q;
  logic        wb_write;
  logic [15:0] dec_out;

  logic [3:0]  f_op, f_opext, f_rdest, f_rsrc;
  logic        f_is_cmp, f_is_nop;
  logic        accept;

  assign f_op     = field4(instr, OP_LSB);
  assign f_opext  = field4(instr, OPEXT_LSB);
  assign f_rdest  = field4(instr, RDEST_LSB);
  assign f_rsrc   = field4(instr, RSRC_LSB);
  assign f_is_nop = (instr == 16'h0000);
  assign f_is_cmp = (f_op == OP_CMPI) || ((f_op == OP_REG) && (f_opext == EXT_CMP));
  assign accept   = instr_valid && instr_ready;

  // Fields are captured on acceptance so they hold steady from DECODE through WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      run_q      <= 1'b0;
      opcode     <= 8'h00;
      rsrc       <= 4'h0;
      rdest      <= 4'h0;
      imm        <= 16'h0000;
      ror_i      <= 1'b0;
      is_halt_q  <= 1'b0;
      no_write_q <= 1'b0;
      no_flag_q  <= 1'b0;
      retired    <= 16'h0000;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      if (accept) begin
        rsrc       <= f_rsrc;
        rdest      <= f_rdest;
        is_halt_q  <= (f_op == OP_HALT);
        no_write_q <= f_is_nop || f_is_cmp;
        no_flag_q  <= f_is_nop;
        if (f_op == OP_REG) begin
          opcode <= {4'h0, f_opext};
          imm    <= 16'h0000;
          ror_i  <= 1'b0;
        end else begin
          opcode <= {f_op, 4'h0};
          imm    <= sext8(instr[IMM8_LSB +: 8]);
          ror_i  <= 1'b1;
        end
      end
      if (state == WB) begin
        retired <= retired + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    wb_write    = 1'b0;
    flag_en     = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        instr_ready = run_q;
        if (instr_valid && run_q) state_nxt = DECODE;
      end
      DECODE:  state_nxt = is_halt_q ? HALT : EXEC;
      EXEC:    state_nxt = WB;
      WB: begin
        wb_write  = !no_write_q;
        flag_en   = !no_flag_q;
        state_nxt = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  onehot_dec4 u_dec (
    .sel (rdest),
    .out (dec_out)
  );

  assign reg_enable = wb_write ? dec_out : 16'h0000;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: each instruction is checked cycle by cycle against
// expectations derived from its fields and the acceptance-relative timeline.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [3:0]  rsrc;
  logic [3:0]  rdest;
  logic [15:0] imm;
  logic        ror_i;
  logic [15:0] reg_enable;
  logic        flag_en;
  logic        halted;
  logic [15:0] retired;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_retired = 16'h0000;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rsrc        (rsrc),
    .rdest       (rdest),
    .imm         (imm),
    .ror_i       (ror_i),
    .reg_enable  (reg_enable),
    .flag_en     (flag_en),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " reg_enable"}, {16'h0, reg_enable}, 32'h0);
    check_eq({tag, " flag_en"}, {31'h0, flag_en}, 32'h0);
  endtask

  // Offer word w after 'gap' idle FETCH cycles, then follow it to completion.
  task automatic run_instr(input logic [15:0] w, input int gap);
    logic [3:0]  op, ext, rd, rs;
    logic [7:0]  exp_opc;
    logic [15:0] exp_imm, exp_wen;
    logic        exp_flag, is_cmp;
    int          s;
    op  = w[15:12];
    rd  = w[11:8];
    ext = w[7:4];
    rs  = w[3:0];
    is_cmp   = (op == 4'hB) || (op == 4'h0 && ext == 4'hB);
    exp_opc  = (op == 4'h0) ? {4'h0, ext} : {op, 4'h0};
    s        = int'(w[7:0]);
    if (s > 127) s -= 256;
    exp_imm  = (op == 4'h0) ? 16'h0 : s[15:0];
    exp_wen  = (w == 16'h0 || is_cmp) ? 16'h0 : (16'h1 << rd);
    exp_flag = (w != 16'h0);

    for (int i = 0; i <= gap; i++) begin
      @(negedge clk);
      check_eq("fetch ready", {31'h0, instr_ready}, 32'h1);
      check_eq("fetch retired", {16'h0, retired}, {16'h0, exp_retired});
      check_idle("fetch");
      instr       = (i == gap) ? w : 16'($urandom);
      instr_valid = (i == gap);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    check_eq("decode ready", {31'h0, instr_ready}, 32'h0);
    check_eq("decode halted", {31'h0, halted}, 32'h0);
    check_idle("decode");
    if (op == 4'hF) begin
      @(negedge clk);
      check_eq("halt halted", {31'h0, halted}, 32'h1);
      for (int i = 0; i < 6; i++) begin
        check_eq("halt ready", {31'h0, instr_ready}, 32'h0);
        check_eq("halt retired", {16'h0, retired}, {16'h0, exp_retired});
        check_idle("halt");
        instr_valid = 1'b1;
        instr       = 16'($urandom);
        @(negedge clk);
        check_eq("halt sticky", {31'h0, halted}, 32'h1);
      end
      instr_valid = 1'b0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("opcode", {24'h0, opcode}, {24'h0, exp_opc});
      check_eq("rsrc", {28'h0, rsrc}, {28'h0, rs});
      check_eq("rdest", {28'h0, rdest}, {28'h0, rd});
      check_eq("imm", {16'h0, imm}, {16'h0, exp_imm});
      check_eq("ror_i", {31'h0, ror_i}, {31'h0, (op != 4'h0)});
      check_eq("busy ready", {31'h0, instr_ready}, 32'h0);
      check_eq("busy retired", {16'h0, retired}, {16'h0, exp_retired});
      if (c == 0) begin
        check_idle("exec");
      end else begin
        check_eq("wb reg_enable", {16'h0, reg_enable}, {16'h0, exp_wen});
        check_eq("wb flag_en", {31'h0, flag_en}, {31'h0, exp_flag});
      end
    end
    exp_retired = exp_retired + 16'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " ready"}, {31'h0, instr_ready}, 32'h0);
    check_eq({tag, " opcode"}, {24'h0, opcode}, 32'h0);
    check_eq({tag, " rsrc"}, {28'h0, rsrc}, 32'h0);
    check_eq({tag, " rdest"}, {28'h0, rdest}, 32'h0);
    check_eq({tag, " imm"}, {16'h0, imm}, 32'h0);
    check_eq({tag, " ror_i"}, {31'h0, ror_i}, 32'h0);
    check_eq({tag, " halted"}, {31'h0, halted}, 32'h0);
    check_eq({tag, " retired"}, {16'h0, retired}, 32'h0);
    check_idle(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("post-release ready", {31'h0, instr_ready}, 32'h0);
  endtask

  initial begin
    logic [15:0] w;
    rst         = 1'b0;
    instr       = 16'h0;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    run_instr(16'h0351, 0);
    run_instr(16'h52FF, 0);
    run_instr(16'hB47F, 1);
    run_instr(16'h00B2, 0);
    run_instr(16'h0000, 5);

    for (int n = 0; n < 200; n++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
      case ($urandom_range(0, 7))
        0:       w = 16'h0000;
        1:       begin w[15:12] = 4'h0; w[7:4] = 4'hB; end
        2:       w[15:12] = 4'h0;
        default: ;
      endcase
      run_instr(w, $urandom_range(0, 3));
    end

    // Abort mid-EXEC: nothing may be written and the retire count clears.
    @(negedge clk);
    check_eq("abort fetch ready", {31'h0, instr_ready}, 32'h1);
    instr_valid = 1'b1;
    instr       = 16'h0351;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("abort exec opcode", {24'h0, opcode}, 32'h05);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_retired = 16'h0;
    repeat (3) begin
      @(negedge clk);
      check_idle("abort hold");
    end
    release_reset();
    run_instr(16'h0351, 0);

    run_instr(16'hF000, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("halt reset");
    exp_retired = 16'h0;
    release_reset();
    run_instr(16'h52FF, 0);
    @(negedge clk);
    check_eq("final retired", {16'h0, retired}, {16'h0, exp_retired});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
